// File: rtl/fetch_sequencer.sv
// Instruction fetch and PC sequencing: FETCH -> LATCH -> EXEC, holds the IR for the
// decoder until exec_done, then selects sequential, branch, jump or JAL next PC.
module fetch_sequencer #(
    parameter int unsigned          ADDR_W    = 16,
    parameter logic [ADDR_W-1:0]    BOOT_ADDR = '0
) (
    input  logic                clk,
    input  logic                reset_n,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_en,
    input  logic [15:0]         mem_rdata,
    output logic [15:0]         instr_out,
    output logic                ir_valid,
    input  logic                exec_done,
    input  logic [4:0]          flags,
    input  logic [15:0]         rtarget_data,
    output logic                link_we,
    output logic [3:0]          link_addr,
    output logic [15:0]         link_data,
    output logic [ADDR_W-1:0]   pc_out
);

    localparam int unsigned DISP_W = 8;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        LATCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [15:0]         ir_q, ir_d;

    logic                flag_f, flag_l, flag_n, flag_c, flag_z;
    logic                cond_true;
    logic                is_bcond, is_jcond, is_jal;
    logic [7:0]          op;
    logic [ADDR_W-1:0]   pc_inc, disp_ext, pc_branch, jump_target, next_pc;

    assign {flag_f, flag_l, flag_n, flag_c, flag_z} = flags;

    // Instruction class decode from the held IR
    assign op       = {ir_q[15:12], ir_q[7:4]};
    assign is_bcond = (ir_q[15:12] == 4'b1100);
    assign is_jcond = (op == 8'b0100_1100);
    assign is_jal   = (op == 8'b0100_1000);

    // Branch condition evaluated against the live flag register
    always_comb begin
        cond_true = 1'b0;
        case (ir_q[11:8])
            4'd0:    cond_true = flag_z;
            4'd1:    cond_true = !flag_z;
            4'd2:    cond_true = flag_c;
            4'd3:    cond_true = !flag_c;
            4'd4:    cond_true = flag_l;
            4'd5:    cond_true = !flag_l;
            4'd6:    cond_true = flag_n;
            4'd7:    cond_true = !flag_n;
            4'd8:    cond_true = flag_f;
            4'd9:    cond_true = !flag_f;
            4'd10:   cond_true = !flag_l && !flag_z;
            4'd11:   cond_true = flag_l || flag_z;
            4'd12:   cond_true = !flag_n && !flag_z;
            4'd13:   cond_true = flag_n || flag_z;
            4'd14:   cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    // Address arithmetic wraps modulo 2^ADDR_W; displacement is relative to the branch itself
    assign pc_inc      = pc_q + ADDR_W'(1);
    assign disp_ext    = {{(ADDR_W-DISP_W){ir_q[7]}}, ir_q[7:0]};
    assign pc_branch   = pc_q + disp_ext;
    assign jump_target = rtarget_data[ADDR_W-1:0];

    always_comb begin
        next_pc = pc_inc;
        if (is_bcond && cond_true) begin
            next_pc = pc_branch;
        end else if ((is_jcond && cond_true) || is_jal) begin
            next_pc = jump_target;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FETCH;
            pc_q    <= BOOT_ADDR;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        link_we = 1'b0;
        case (state_q)
            FETCH: state_d = LATCH;
            LATCH: begin
                ir_d    = mem_rdata;
                state_d = EXEC;
            end
            EXEC: begin
                if (exec_done) begin
                    pc_d    = next_pc;
                    state_d = FETCH;
                    link_we = is_jal;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // reset_n gates mem_en so no read is issued while reset holds the FSM in FETCH
    assign mem_en    = reset_n && (state_q == FETCH);
    assign mem_addr  = pc_q;
    assign pc_out    = pc_q;
    assign instr_out = ir_q;
    assign ir_valid  = (state_q == EXEC);
    assign link_addr = ir_q[11:8];
    assign link_data = 16'(pc_inc);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized
// instructions checked against a behavioural next-PC model.
module tb_fetch_sequencer;

    logic        clk;
    logic        reset_n;
    logic [15:0] mem_addr;
    logic        mem_en;
    logic [15:0] mem_rdata;
    logic [15:0] instr_out;
    logic        ir_valid;
    logic        exec_done;
    logic [4:0]  flags;
    logic [15:0] rtarget_data;
    logic        link_we;
    logic [3:0]  link_addr;
    logic [15:0] link_data;
    logic [15:0] pc_out;

    int checks   = 0;
    int failures = 0;

    logic [15:0] imem [0:65535];
    logic [15:0] model_pc;

    fetch_sequencer #(.ADDR_W(16), .BOOT_ADDR(16'h0000)) dut (
        .clk(clk), .reset_n(reset_n),
        .mem_addr(mem_addr), .mem_en(mem_en), .mem_rdata(mem_rdata),
        .instr_out(instr_out), .ir_valid(ir_valid),
        .exec_done(exec_done), .flags(flags), .rtarget_data(rtarget_data),
        .link_we(link_we), .link_addr(link_addr), .link_data(link_data),
        .pc_out(pc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memory: data valid the cycle after mem_en
    always @(posedge clk) begin
        if (mem_en) mem_rdata <= imem[mem_addr];
    end

    function automatic bit model_cond(input logic [3:0] cc, input logic [4:0] fl);
        bit f = fl[4];
        bit l = fl[3];
        bit n = fl[2];
        bit c = fl[1];
        bit z = fl[0];
        case (cc)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return l;
            4'd5:  return !l;
            4'd6:  return n;
            4'd7:  return !n;
            4'd8:  return f;
            4'd9:  return !f;
            4'd10: return !l && !z;
            4'd11: return l || z;
            4'd12: return !n && !z;
            4'd13: return n || z;
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit model_is_jal(input logic [15:0] ir);
        return (ir[15:12] == 4'h4) && (ir[7:4] == 4'h8);
    endfunction

    function automatic logic [15:0] model_next(input logic [15:0] pc, input logic [15:0] ir,
                                               input logic [4:0] fl, input logic [15:0] rt);
        int d;
        int t;
        if (ir[15:12] == 4'hC) begin
            if (!model_cond(ir[11:8], fl)) return pc + 16'd1;
            d = int'(ir[7:0]);
            if (d >= 128) d = d - 256;
            t = (int'(pc) + d + 65536) % 65536;
            return 16'(t);
        end
        if (ir[15:12] == 4'h4 && ir[7:4] == 4'hC)
            return model_cond(ir[11:8], fl) ? rt : pc + 16'd1;
        if (model_is_jal(ir)) return rt;
        return pc + 16'd1;
    endfunction

    // Drives one instruction through FETCH/LATCH/EXEC; called just after a negedge in FETCH
    task automatic run_instr(input logic [15:0] instr, input logic [4:0] fl, input logic [15:0] rt,
                             input int hold, input bit noise,
                             output logic [15:0] o_faddr, output logic o_fen, output logic o_fvalid,
                             output int o_lat, output logic [15:0] o_ir, output bit o_stable,
                             output bit o_hold_lwe, output logic o_lwe, output logic [3:0] o_laddr,
                             output logic [15:0] o_ldata, output logic o_post_lwe,
                             output logic o_post_valid, output logic [15:0] o_next);
        imem[model_pc] = instr;
        exec_done = noise;
        #1;
        o_faddr  = mem_addr;
        o_fen    = mem_en;
        o_fvalid = ir_valid;
        o_lat    = 0;
        while (ir_valid !== 1'b1 && o_lat < 6) begin
            @(negedge clk); #1;
            o_lat++;
        end
        exec_done  = 1'b0;
        o_ir       = instr_out;
        o_stable   = 1'b1;
        o_hold_lwe = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk); #1;
            if (instr_out !== o_ir || ir_valid !== 1'b1) o_stable = 1'b0;
            if (link_we !== 1'b0) o_hold_lwe = 1'b1;
        end
        flags        = fl;
        rtarget_data = rt;
        exec_done    = 1'b1;
        #1;
        o_lwe   = link_we;
        o_laddr = link_addr;
        o_ldata = link_data;
        @(posedge clk); #1;
        exec_done    = 1'b0;
        o_post_lwe   = link_we;
        o_post_valid = ir_valid;
        @(negedge clk);
        o_next = mem_addr;
    endtask

    logic [15:0] r_faddr, r_ir, r_ldata, r_next;
    logic        r_fen, r_fvalid, r_lwe, r_post_lwe, r_post_valid;
    logic [3:0]  r_laddr;
    int          r_lat;
    bit          r_stable, r_hold_lwe;

    task automatic goto(input logic [15:0] addr);
        run_instr(16'h4EC0, 5'd0, addr, 0, 1'b0, r_faddr, r_fen, r_fvalid, r_lat, r_ir, r_stable,
                  r_hold_lwe, r_lwe, r_laddr, r_ldata, r_post_lwe, r_post_valid, r_next);
        model_pc = addr;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; exec_done = 1'b0; flags = 5'd0; rtarget_data = 16'd0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL reset_mem_en got=%b exp=0", mem_en); end
        checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL reset_ir_valid got=%b exp=0", ir_valid); end
        checks++; if (link_we !== 1'b0) begin failures++; $display("FAIL reset_link_we got=%b exp=0", link_we); end
        checks++; if (pc_out !== 16'h0000) begin failures++; $display("FAIL reset_pc got=%h exp=0000", pc_out); end
        checks++; if (instr_out !== 16'h0000) begin failures++; $display("FAIL reset_ir got=%h exp=0000", instr_out); end
        @(negedge clk);
        reset_n  = 1'b1;
        model_pc = 16'h0000;
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            run_instr(16'h0512, 5'd0, 16'h0, 0, 1'b0, r_faddr, r_fen, r_fvalid, r_lat, r_ir, r_stable,
                      r_hold_lwe, r_lwe, r_laddr, r_ldata, r_post_lwe, r_post_valid, r_next);
            checks++; if (r_faddr !== 16'(i) || r_fen !== 1'b1) begin failures++;
                $display("FAIL seq_fetch[%0d] got=%h/%b exp=%h/1", i, r_faddr, r_fen, 16'(i)); end
            checks++; if (r_lat != 2 || r_fvalid !== 1'b0 || r_post_valid !== 1'b0) begin failures++;
                $display("FAIL seq_timing[%0d] got lat=%0d fv=%b pv=%b exp lat=2 fv=0 pv=0", i, r_lat, r_fvalid, r_post_valid); end
            checks++; if (r_ir !== 16'h0512) begin failures++; $display("FAIL seq_ir[%0d] got=%h exp=0512", i, r_ir); end
            model_pc = model_pc + 16'd1;
        end
        #1;
        checks++; if (mem_addr !== 16'h0003) begin failures++; $display("FAIL seq_next got=%h exp=0003", mem_addr); end
    endtask

    task automatic test_bcond();
        goto(16'h0010);
        run_instr(16'hC0FE, 5'b00001, 16'h0, 1, 1'b0, r_faddr, r_fen, r_fvalid, r_lat, r_ir, r_stable,
                  r_hold_lwe, r_lwe, r_laddr, r_ldata, r_post_lwe, r_post_valid, r_next);
        checks++; if (r_faddr !== 16'h0010 || r_next !== 16'h000E) begin failures++;
            $display("FAIL bcond_eq_taken got=%h->%h exp=0010->000e", r_faddr, r_next); end
        model_pc = 16'h000E;
        goto(16'h0010);
        run_instr(16'hC0FE, 5'b00000, 16'h0, 0, 1'b0, r_faddr, r_fen, r_fvalid, r_lat, r_ir, r_stable,
                  r_hold_lwe, r_lwe, r_laddr, r_ldata, r_post_lwe, r_post_valid, r_next);
        checks++; if (r_next !== 16'h0011) begin failures++; $display("FAIL bcond_eq_not got=%h exp=0011", r_next); end
        model_pc = 16'h0011;
    endtask

    task automatic test_jcond();
        goto(16'h0040);
        run_instr(16'h4CC3, 5'b00000, 16'h0200, 0, 1'b0, r_faddr, r_fen, r_fvalid, r_lat, r_ir, r_stable,
                  r_hold_lwe, r_lwe, r_laddr, r_ldata, r_post_lwe, r_post_valid, r_next);
        checks++; if (r_next !== 16'h0200 || r_lwe !== 1'b0) begin failures++;
            $display("FAIL jcond_lt_taken got=%h lwe=%b exp=0200 lwe=0", r_next, r_lwe); end
        model_pc = 16'h0200;
        run_instr(16'h4CC3, 5'b00001, 16'h0200, 0, 1'b0, r_faddr, r_fen, r_fvalid, r_lat, r_ir, r_stable,
                  r_hold_lwe, r_lwe, r_laddr, r_ldata, r_post_lwe, r_post_valid, r_next);
        checks++; if (r_next !== 16'h0201) begin failures++; $display("FAIL jcond_lt_not got=%h exp=0201", r_next); end
        model_pc = 16'h0201;
    endtask

    task automatic test_jal();
        goto(16'h0030);
        run_instr(16'h4E85, 5'b10101, 16'h0100, 2, 1'b0, r_faddr, r_fen, r_fvalid, r_lat, r_ir, r_stable,
                  r_hold_lwe, r_lwe, r_laddr, r_ldata, r_post_lwe, r_post_valid, r_next);
        checks++; if (r_lwe !== 1'b1 || r_laddr !== 4'd14 || r_ldata !== 16'h0031) begin failures++;
            $display("FAIL jal_link got we=%b a=%0d d=%h exp we=1 a=14 d=0031", r_lwe, r_laddr, r_ldata); end
        checks++; if (r_post_lwe !== 1'b0 || r_hold_lwe) begin failures++;
            $display("FAIL jal_strobe_width got post=%b hold=%b exp 0/0", r_post_lwe, r_hold_lwe); end
        checks++; if (r_next !== 16'h0100) begin failures++; $display("FAIL jal_target got=%h exp=0100", r_next); end
        model_pc = 16'h0100;
        run_instr(16'h4585, 5'b00000, 16'h0777, 0, 1'b0, r_faddr, r_fen, r_fvalid, r_lat, r_ir, r_stable,
                  r_hold_lwe, r_lwe, r_laddr, r_ldata, r_post_lwe, r_post_valid, r_next);
        checks++; if (r_next !== 16'h0777 || r_laddr !== 4'd5 || r_ldata !== 16'h0101) begin failures++;
            $display("FAIL jal_self got=%h a=%0d d=%h exp=0777 a=5 d=0101", r_next, r_laddr, r_ldata); end
        model_pc = 16'h0777;
    endtask

    task automatic test_wrap();
        goto(16'hFFFF);
        run_instr(16'h0512, 5'd0, 16'h0, 0, 1'b0, r_faddr, r_fen, r_fvalid, r_lat, r_ir, r_stable,
                  r_hold_lwe, r_lwe, r_laddr, r_ldata, r_post_lwe, r_post_valid, r_next);
        checks++; if (r_next !== 16'h0000) begin failures++; $display("FAIL wrap_seq got=%h exp=0000", r_next); end
        model_pc = 16'h0000;
        goto(16'hFFF0);
        run_instr(16'hCE7F, 5'd0, 16'h0, 0, 1'b0, r_faddr, r_fen, r_fvalid, r_lat, r_ir, r_stable,
                  r_hold_lwe, r_lwe, r_laddr, r_ldata, r_post_lwe, r_post_valid, r_next);
        checks++; if (r_next !== 16'h006F) begin failures++; $display("FAIL wrap_bcond got=%h exp=006f", r_next); end
        model_pc = 16'h006F;
        run_instr(16'hCE00, 5'd0, 16'h0, 0, 1'b0, r_faddr, r_fen, r_fvalid, r_lat, r_ir, r_stable,
                  r_hold_lwe, r_lwe, r_laddr, r_ldata, r_post_lwe, r_post_valid, r_next);
        checks++; if (r_next !== 16'h006F) begin failures++; $display("FAIL spin_disp0 got=%h exp=006f", r_next); end
        run_instr(16'hCF05, 5'b11111, 16'h0, 0, 1'b0, r_faddr, r_fen, r_fvalid, r_lat, r_ir, r_stable,
                  r_hold_lwe, r_lwe, r_laddr, r_ldata, r_post_lwe, r_post_valid, r_next);
        checks++; if (r_next !== 16'h0070) begin failures++; $display("FAIL bcond_never got=%h exp=0070", r_next); end
        model_pc = 16'h0070;
    endtask

    task automatic test_hold_reset();
        logic [15:0] ir0;
        int          lat;
        bit          stable;
        bit          lwe_seen;
        imem[model_pc] = 16'h4E85;
        lat = 0;
        #1;
        while (ir_valid !== 1'b1 && lat < 6) begin @(negedge clk); #1; lat++; end
        checks++; if (ir_valid !== 1'b1) begin failures++; $display("FAIL hold_enter_exec got=%b exp=1", ir_valid); end
        ir0 = instr_out;
        stable = 1'b1;
        lwe_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (instr_out !== ir0 || ir_valid !== 1'b1) stable = 1'b0;
            if (link_we !== 1'b0) lwe_seen = 1'b1;
        end
        checks++; if (!stable || ir0 !== 16'h4E85 || lwe_seen) begin failures++;
            $display("FAIL hold_stable got ir=%h stable=%b lwe=%b exp ir=4e85 stable=1 lwe=0", ir0, stable, lwe_seen); end
        rtarget_data = 16'h1234;
        exec_done    = 1'b1;
        #1;
        reset_n = 1'b0;
        #1;
        checks++; if (link_we !== 1'b0 || ir_valid !== 1'b0 || mem_en !== 1'b0) begin failures++;
            $display("FAIL midreset_outputs got we=%b v=%b en=%b exp 0/0/0", link_we, ir_valid, mem_en); end
        checks++; if (pc_out !== 16'h0000 || instr_out !== 16'h0000) begin failures++;
            $display("FAIL midreset_state got pc=%h ir=%h exp 0000/0000", pc_out, instr_out); end
        @(posedge clk); #1;
        exec_done = 1'b0;
        checks++; if (pc_out !== 16'h0000) begin failures++; $display("FAIL midreset_pc_hold got=%h exp=0000", pc_out); end
        @(negedge clk);
        reset_n  = 1'b1;
        model_pc = 16'h0000;
        #1;
        checks++; if (mem_en !== 1'b1 || mem_addr !== 16'h0000) begin failures++;
            $display("FAIL midreset_fetch got en=%b a=%h exp en=1 a=0000", mem_en, mem_addr); end
    endtask

    task automatic test_random();
        logic [15:0] instr, rt, exp_next;
        logic [4:0]  fl;
        int          kind;
        for (int n = 0; n < 80; n++) begin
            kind = $urandom_range(0, 4);
            rt   = 16'($urandom);
            fl   = 5'($urandom);
            case (kind)
                0: instr = 16'($urandom);
                1: instr = {4'hC, 4'($urandom), 8'($urandom)};
                2: instr = {4'h4, 4'($urandom), 4'hC, 4'($urandom)};
                3: instr = {4'h4, 4'($urandom), 4'h8, 4'($urandom)};
                default: instr = {4'hC, 4'd14, 8'($urandom)};
            endcase
            exp_next = model_next(model_pc, instr, fl, rt);
            run_instr(instr, fl, rt, $urandom_range(0, 3), 1'($urandom), r_faddr, r_fen, r_fvalid, r_lat,
                      r_ir, r_stable, r_hold_lwe, r_lwe, r_laddr, r_ldata, r_post_lwe, r_post_valid, r_next);
            checks++;
            if (r_faddr !== model_pc || r_ir !== instr || !r_stable || r_lat != 2) begin failures++;
                $display("FAIL rand_fetch[%0d] got a=%h ir=%h st=%b lat=%0d exp a=%h ir=%h st=1 lat=2",
                         n, r_faddr, r_ir, r_stable, r_lat, model_pc, instr); end
            checks++;
            if (r_lwe !== 1'(model_is_jal(instr)) || r_hold_lwe || r_post_lwe !== 1'b0 ||
                (model_is_jal(instr) && (r_laddr !== instr[11:8] || r_ldata !== model_pc + 16'd1))) begin
                failures++;
                $display("FAIL rand_link[%0d] got we=%b a=%0d d=%h exp we=%b a=%0d d=%h", n, r_lwe,
                         r_laddr, r_ldata, model_is_jal(instr), instr[11:8], model_pc + 16'd1); end
            checks++;
            if (r_next !== exp_next) begin failures++;
                $display("FAIL rand_next[%0d] ir=%h fl=%b got=%h exp=%h", n, instr, fl, r_next, exp_next); end
            model_pc = exp_next;
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_bcond();
        test_jcond();
        test_jal();
        test_wrap();
        test_hold_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Upstream instruction-fetch and PC-sequencing stage of the 16-bit CPU.
- Reads an instruction from synchronous instruction memory and holds it in an instruction register (IR) that feeds the decoder.
- Holds the IR until the execute datapath signals completion, then selects the next PC.
- Next-PC choices: sequential, Bcond (PC-relative), Jcond (register target) or JAL (register target plus link write).

Parameters:
- ADDR_W, 16, width of PC and instruction-memory address.
- BOOT_ADDR, 16'h0000, PC value loaded on reset.

Ports:
- clk, input, 1, system clock; all state changes on rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- mem_addr, output, ADDR_W, instruction-memory address; equals PC.
- mem_en, output, 1, instruction-memory read enable.
- mem_rdata, input, 16, instruction word, valid one cycle after mem_en.
- instr_out, output, 16, IR contents to the decoder.
- ir_valid, output, 1, high while IR holds an instruction awaiting execution.
- exec_done, input, 1, execute stage finished the current instruction.
- flags, input, 5, {F, L, N, C, Z} from the flag register, sampled on exec_done.
- rtarget_data, input, 16, register-file value of IR[3:0] (jump target).
- link_we, output, 1, one-cycle write strobe for the JAL link register.
- link_addr, output, 4, link register index = IR[11:8].
- link_data, output, 16, PC+1 (zero-extended) for the JAL link.
- pc_out, output, ADDR_W, current PC, for debug and the display bus.

Behaviour:
- Reset (async, reset_n=0):
  - PC=BOOT_ADDR, IR=16'h0000, state=FETCH.
  - ir_valid=0, link_we=0, mem_en=0 while in reset.
- FSM states FETCH -> LATCH -> EXEC:
  - FETCH: mem_en=1, mem_addr=PC; next state LATCH.
  - LATCH: IR<=mem_rdata; mem_en=0; next state EXEC.
  - EXEC: ir_valid=1; stays in EXEC while exec_done=0.
  - EXEC with exec_done=1: PC<=next_pc and state<=FETCH on the same edge.
- Throughput: minimum 3 cycles per instruction. exec_done is ignored outside EXEC.
- IR classification, using op={IR[15:12], IR[7:4]}:
  - BCOND: IR[15:12]=4'b1100.
  - JCOND: op=8'b01001100.
  - JAL: op=8'b01001000.
  - Anything else is sequential.
- Condition cond=IR[11:8], evaluated against flags on the exec_done cycle:
  - EQ=0:Z, NE=1:!Z, CS=2:C, CC=3:!C, HI=4:L, LS=5:!L.
  - GT=6:N, LE=7:!N, FS=8:F, FC=9:!F.
  - LO=10:!L&!Z, HS=11:L|Z, LT=12:!N&!Z, GE=13:N|Z.
  - UC=14:always, 15:never.
- next_pc:
  - BCOND taken: PC + sign_extend({IR[7:4],IR[3:0]}); relative to the branch's own address. Not taken: PC+1.
  - JCOND taken: rtarget_data[ADDR_W-1:0]. Not taken: PC+1.
  - JAL: rtarget_data[ADDR_W-1:0], unconditional.
  - All others: PC+1.
- PC arithmetic is modulo 2^ADDR_W:
  - PC=16'hFFFF sequential wraps to 0.
  - Negative displacements wrap below 0.
  - Displacement 0 is legal and re-fetches the same address (spin loop).
- JAL link write:
  - link_we=1 combinationally only in EXEC with exec_done=1 and IR=JAL.
  - link_data=PC+1 is the pre-update value; link_addr=IR[11:8].
  - If link_addr equals IR[3:0], the jump target is the old register value (rtarget_data sampled the same cycle).
- Reset mid-operation: in any state, an immediate return to the reset values. An in-flight link write is suppressed and no partial PC update occurs.
- instr_out is stable from entry to EXEC until the next LATCH. The decoder input never changes while ir_valid=1.

Test Plan:
- Reset release, BOOT_ADDR=0, memory holds ADD at 0..2, exec_done pulsed each EXEC -> mem_addr sequence 0,1,2. Each instruction takes 3 cycles. ir_valid high only in EXEC.
- BCOND EQ, disp=8'hFE, at PC=16'h0010, Z=1 -> next fetch at 16'h000E. Same with Z=0 -> 16'h0011.
- JCOND LT (cond=12), N=0, Z=0, rtarget_data=16'h0200 -> next fetch 16'h0200. Same with Z=1 -> PC+1.
- JAL at PC=16'h0030, IR[11:8]=4'd14, rtarget_data=16'h0100 -> one-cycle link_we with link_addr=14 and link_data=16'h0031; next fetch 16'h0100.
- PC=16'hFFFF, sequential instruction -> next mem_addr 16'h0000. BCOND UC with disp=8'h7F at PC=16'hFFF0 -> 16'h006F.
- Hold exec_done low for 10 cycles, then drop reset_n mid-EXEC of a JAL -> instr_out stable throughout the hold. On reset: no link_we, PC=BOOT_ADDR, state FETCH.
